// File: rtl/tdm_demux1x8.sv
// Receive side of an 8:1 TDM link: aligns on frame_sync, collects samples in a
// shadow buffer and publishes all eight channels together on frame completion.
module tdm_demux1x8 #(
  parameter int unsigned WIDTH        = 1,
  parameter bit          REQUIRE_SYNC = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h,
  output logic             out_valid,
  output logic [2:0]       ch_sel,
  output logic             locked,
  output logic             sync_err
);

  typedef enum logic {StHunt, StLocked} state_e;

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  // Channel h never needs a shadow slot: it is taken straight from din.
  logic [WIDTH-1:0] shadow_q [7];
  logic [WIDTH-1:0] shadow_d [7];
  logic [WIDTH-1:0] out_q [8];
  logic [WIDTH-1:0] out_d [8];
  logic             out_valid_q, out_valid_d;
  logic             sync_err_q, sync_err_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    sync_err_d  = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        StHunt: begin
          if (frame_sync) begin
            shadow_d[0] = din;
            cnt_d       = 3'd1;
            state_d     = StLocked;
          end
        end
        StLocked: begin
          if (frame_sync && (cnt_q != 3'd0)) begin
            // Misplaced sync restarts the frame at channel a.
            sync_err_d  = 1'b1;
            shadow_d[0] = din;
            cnt_d       = 3'd1;
          end else if (!frame_sync && (cnt_q == 3'd0) && REQUIRE_SYNC) begin
            sync_err_d = 1'b1;
            cnt_d      = 3'd0;
            state_d    = StHunt;
          end else if (cnt_q == 3'd7) begin
            for (int i = 0; i < 7; i++) begin
              out_d[i] = shadow_q[i];
            end
            out_d[7]    = din;
            out_valid_d = 1'b1;
            cnt_d       = 3'd0;
          end else begin
            shadow_d[cnt_q] = din;
            cnt_d           = cnt_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StHunt;
      cnt_q       <= 3'd0;
      shadow_q    <= '{default: '0};
      out_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign a         = out_q[0];
  assign b         = out_q[1];
  assign c         = out_q[2];
  assign d         = out_q[3];
  assign e         = out_q[4];
  assign f         = out_q[5];
  assign g         = out_q[6];
  assign h         = out_q[7];
  assign out_valid = out_valid_q;
  assign sync_err  = sync_err_q;
  assign ch_sel    = cnt_q;
  assign locked    = (state_q == StLocked);

endmodule

// File: tb/tb_tdm_demux1x8.sv
// Bench for tdm_demux1x8: two instances (strict and lock-once sync) checked
// every cycle against a frame-level model, plus directed literal checks.
module tb_tdm_demux1x8;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         frame_sync = 1'b0;

  logic [W-1:0] sa, sb, sc, sd, se, sf, sg, sh;
  logic [W-1:0] na, nb, nc, nd, ne, nf, ng, nh;
  logic         s_ov, s_err, s_lock, n_ov, n_err, n_lock;
  logic [2:0]   s_ch, n_ch;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tdm_demux1x8 #(.WIDTH(W), .REQUIRE_SYNC(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .a(sa), .b(sb), .c(sc), .d(sd), .e(se), .f(sf), .g(sg), .h(sh),
    .out_valid(s_ov), .ch_sel(s_ch), .locked(s_lock), .sync_err(s_err)
  );

  tdm_demux1x8 #(.WIDTH(W), .REQUIRE_SYNC(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .a(na), .b(nb), .c(nc), .d(nd), .e(ne), .f(nf), .g(ng), .h(nh),
    .out_valid(n_ov), .ch_sel(n_ch), .locked(n_lock), .sync_err(n_err)
  );

  wire [8*W-1:0] s_out = {sh, sg, sf, se, sd, sc, sb, sa};
  wire [8*W-1:0] n_out = {nh, ng, nf, ne, nd, nc, nb, na};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Eight consecutive 4-bit values starting at base, channel a in the low nibble.
  function automatic logic [31:0] frame_of(input int base);
    logic [31:0] r;
    for (int i = 0; i < 8; i++) r[4*i +: 4] = 4'(base + i);
    return r;
  endfunction

  // Model: per instance, a hunt/locked flag, the list of samples gathered so far
  // in the current frame, and the last published frame.
  bit          m_lock [2];
  int          m_cnt  [2];
  logic [3:0]  m_buf  [2][8];
  logic [31:0] m_out  [2];
  bit          m_ov   [2];
  bit          m_err  [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_lock[k] = 0; m_cnt[k] = 0; m_out[k] = '0; m_ov[k] = 0; m_err[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input bit req, input bit v, input bit s,
                            input logic [3:0] dv);
    m_ov[k]  = 0;
    m_err[k] = 0;
    if (!v) return;
    if (!m_lock[k]) begin
      if (s) begin
        m_buf[k][0] = dv; m_cnt[k] = 1; m_lock[k] = 1;
      end
    end else if (s && m_cnt[k] != 0) begin
      m_err[k] = 1; m_buf[k][0] = dv; m_cnt[k] = 1;
    end else if (!s && m_cnt[k] == 0 && req) begin
      m_err[k] = 1; m_lock[k] = 0;
    end else begin
      m_buf[k][m_cnt[k]] = dv;
      m_cnt[k]++;
      if (m_cnt[k] == 8) begin
        for (int i = 0; i < 8; i++) m_out[k][4*i +: 4] = m_buf[k][i];
        m_ov[k]  = 1;
        m_cnt[k] = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else begin
      model_step(0, 1'b1, din_valid, frame_sync, din);
      model_step(1, 1'b0, din_valid, frame_sync, din);
    end
    #1;
    chk("strict_data", s_out, m_out[0]);
    chk("strict_status", {28'd0, s_ov, s_err, s_lock, 1'b0} | {29'd0, s_ch},
        {28'd0, m_ov[0], m_err[0], m_lock[0], 1'b0} | {29'd0, 3'(m_cnt[0])});
    chk("loose_data", n_out, m_out[1]);
    chk("loose_status", {28'd0, n_ov, n_err, n_lock, 1'b0} | {29'd0, n_ch},
        {28'd0, m_ov[1], m_err[1], m_lock[1], 1'b0} | {29'd0, 3'(m_cnt[1])});
    if (s_ov && s_err) chk("strict_ov_err_excl", 32'd1, 32'd0);
  end

  // Drive one cycle; returns 2 time units after the edge that consumed it.
  task automatic step(input bit v, input bit s, input logic [3:0] dv);
    din_valid  = v;
    frame_sync = s;
    din        = dv;
    @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input int base, input bit sync_first, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, sync_first && (i == 0), 4'(base + i));
      if (gaps && i != 7) begin
        step(1'b0, 1'b1, 4'hF);
        chk("gap_ch_sel_hold", {29'd0, s_ch}, 32'(i + 1));
      end
    end
  endtask

  initial begin
    int pos;
    bit v, s;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Reset asserted mid-frame clears everything immediately.
    send_frame(1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 4'd3);
    step(1'b1, 1'b0, 4'd4);
    rst_n = 1'b0;
    #1;
    chk("rst_outputs", s_out, 32'd0);
    chk("rst_status", {28'd0, s_ov, s_err, s_lock, s_ch == 3'd0}, 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Hunt discards unsynced samples, then lock and deliver 1..8.
    step(1'b1, 1'b0, 4'd9);
    step(1'b1, 1'b0, 4'd10);
    chk("hunt_discard_unlocked", {31'd0, s_lock}, 32'd0);
    send_frame(1, 1'b1, 1'b0);
    chk("lock_frame_data", s_out, 32'h87654321);
    chk("lock_frame_ov", {30'd0, s_ov, s_lock}, 32'd3);
    step(1'b0, 1'b0, 4'd0);
    chk("ov_one_cycle", {31'd0, s_ov}, 32'd0);

    // Misplaced sync after 3 samples.
    step(1'b1, 1'b1, 4'd1);
    step(1'b1, 1'b0, 4'd2);
    step(1'b1, 1'b0, 4'd3);
    step(1'b1, 1'b1, 4'd5);
    chk("missync_err", {29'd0, s_err, s_ov, s_ch == 3'd1}, 32'd5);
    for (int i = 1; i < 8; i++) step(1'b1, 1'b0, 4'(5 + i));
    chk("missync_data", s_out, frame_of(5));
    chk("missync_ov", {31'd0, s_ov}, 32'd1);

    // Second frame without sync: strict drops lock, loose delivers it.
    step(1'b1, 1'b0, 4'd13);
    chk("nosync_err", {30'd0, s_err, s_lock}, 32'd2);
    for (int i = 1; i < 8; i++) step(1'b1, 1'b0, 4'(13 + i));
    chk("nosync_strict_hold", s_out, frame_of(5));
    chk("nosync_loose_data", n_out, frame_of(13));

    // Gapped frame gives the same result as a gapless one.
    send_frame(1, 1'b1, 1'b1);
    chk("gapped_strict", s_out, 32'h87654321);
    chk("gapped_loose", n_out, 32'h87654321);

    // Back-to-back frames with no idle cycle.
    send_frame(2, 1'b1, 1'b0);
    send_frame(7, 1'b1, 1'b0);
    chk("b2b_data", s_out, frame_of(7));

    pos = 0;
    repeat (3000) begin
      v = ($urandom_range(0, 3) != 0);
      s = 1'b0;
      if (v) begin
        s   = (pos == 0) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 29) == 0);
        pos = (pos + 1) % 8;
      end
      step(v, s, 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
